// File: rtl/id_pipe_chain.sv
// Registered identity chain: STAGES elastic valid/ready slices passing signed samples unchanged.
// Optional output-transfer counter (port xfer_cnt) enabled by defining ID_CHAIN_XFER_CNT_EN.
module id_pipe_chain #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2,
  localparam int unsigned OCC_W = $clog2(STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic signed [WIDTH-1:0] y,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic [OCC_W-1:0]        occupancy
`ifdef ID_CHAIN_XFER_CNT_EN
  ,
  output logic [31:0]             xfer_cnt
`endif
);

  logic [STAGES-1:0]            v_q, v_d;
  logic [STAGES-1:0][WIDTH-1:0] d_q, d_d;
  logic [STAGES:0]              rdy;
  logic [OCC_W-1:0]             occ_q, occ_d;

  // rdy[i] is high when any stage at or after i is empty, or downstream accepts.
  always_comb begin
    logic r;
    r           = y_ready;
    rdy[STAGES] = y_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      r      = r | ~v_q[i];
      rdy[i] = r;
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy[0]) begin
      v_d[0] = x_valid;
      if (x_valid) d_d[0] = x;
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
    end
    occ_d = '0;
    for (int i = 0; i < int'(STAGES); i++) begin
      occ_d = occ_d + OCC_W'(v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

  assign x_ready   = rdy[0];
  assign y         = d_q[STAGES-1];
  assign y_valid   = v_q[STAGES-1];
  assign occupancy = occ_q;

`ifdef ID_CHAIN_XFER_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating count of output handshakes.
  always_comb begin
    cnt_d = cnt_q;
    if (y_valid && y_ready && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
